// File: rtl/seq_mult4_ctrl.sv
// Sequential 4x4 unsigned shift-and-add multiplier: a control FSM with datapath
// plus a saturating iteration counter that tells the FSM when the last add is due.

module contador (
    input  logic       clock,
    input  logic       reset,
    input  logic       init_count,
    input  logic [2:0] count_val,
    output logic       cont_bet_val
);

    logic [2:0] count_r;

    // Iteration counter: cleared whenever the FSM is not iterating, saturates at 7
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_r <= 3'd0;
        end else if (!init_count) begin
            count_r <= 3'd0;
        end else if (count_r != 3'd7) begin
            count_r <= count_r + 3'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign cont_bet_val = (count_r >= count_val);

endmodule

module fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cont_bet_val,
    output logic       init_count,
    output logic [2:0] count_val,
    output logic [7:0] ab_result,
    output logic       done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_r;
    logic [1:0] next_state_s;
    logic [7:0] m_r;
    logic [3:0] q_r;
    logic [7:0] p_r;
    logic [7:0] sum_s;
    logic [7:0] ab_result_r;
    logic       done_r;

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_CALC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cont_bet_val) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_CALC;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Partial product for the current iteration
    always_comb begin
        sum_s = p_r;
        if (q_r[0]) begin
            sum_s = p_r + m_r;
        end else begin
            sum_s = p_r;
        end
    end

    // State register, operand capture, shift-and-add datapath and result register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            m_r         <= 8'd0;
            q_r         <= 4'd0;
            p_r         <= 8'd0;
            ab_result_r <= 8'd0;
            done_r      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        m_r <= {4'd0, a};
                        q_r <= b;
                        p_r <= 8'd0;
                    end else begin
                        m_r <= m_r;
                        q_r <= q_r;
                        p_r <= p_r;
                    end
                end
                ST_CALC: begin
                    p_r <= sum_s;
                    m_r <= {m_r[6:0], 1'b0};
                    q_r <= {1'b0, q_r[3:1]};
                    // The final iteration's sum goes straight to the result register
                    if (cont_bet_val) begin
                        ab_result_r <= sum_s;
                        done_r      <= 1'b1;
                    end else begin
                        ab_result_r <= ab_result_r;
                    end
                end
                ST_DONE: begin
                    done_r <= 1'b0;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign init_count = (state_r == ST_CALC);
    assign count_val  = 3'd3;
    assign ab_result  = ab_result_r;
    assign done       = done_r;

endmodule

module seq_mult4_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] ab_result,
    output logic       done
);

    logic       init_count_s;
    logic [2:0] count_val_s;
    logic       cont_bet_val_s;

    fsm u_fsm (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .a            (a),
        .b            (b),
        .cont_bet_val (cont_bet_val_s),
        .init_count   (init_count_s),
        .count_val    (count_val_s),
        .ab_result    (ab_result),
        .done         (done)
    );

    contador u_contador (
        .clock        (clock),
        .reset        (reset),
        .init_count   (init_count_s),
        .count_val    (count_val_s),
        .cont_bet_val (cont_bet_val_s)
    );

endmodule

// File: tb/tb_seq_mult4_ctrl.sv
// Directed bench for seq_mult4_ctrl: inputs driven and outputs checked on the
// falling clock edge, expected values hand-computed.

module tb_seq_mult4_ctrl;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] ab_result;
    logic       done;

    int checks;
    int errors;
    logic [7:0] prev_result;

    seq_mult4_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .ab_result (ab_result),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One operation from a start pulse: result appears 4 edges after the start edge
    task automatic run_op(input logic [3:0] op_a, input logic [3:0] op_b,
                          input logic [7:0] exp, input string tag);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check({tag, "_done_low"}, {7'd0, done}, 8'd0);
            check({tag, "_hold"}, ab_result, prev_result);
            @(negedge clock);
        end
        check({tag, "_result"}, ab_result, exp);
        check({tag, "_done"}, {7'd0, done}, 8'd1);
        @(negedge clock);
        check({tag, "_done_end"}, {7'd0, done}, 8'd0);
        check({tag, "_keep"}, ab_result, exp);
        prev_result = exp;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        prev_result = 8'd0;
        reset       = 1'b0;
        start       = 1'b1;
        a           = 4'd0;
        b           = 4'd0;

        // Reset held with start high
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_result", ab_result, 8'd0);
            check("rst_done", {7'd0, done}, 8'd0);
        end
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock);
        check("idle_done", {7'd0, done}, 8'd0);

        run_op(4'd3,  4'd5,  8'd15,  "mul_3x5");
        run_op(4'd15, 4'd15, 8'd225, "mul_15x15");
        run_op(4'd0,  4'd9,  8'd0,   "mul_0x9");
        run_op(4'd1,  4'd15, 8'd15,  "mul_1x15");
        run_op(4'd8,  4'd2,  8'd16,  "mul_8x2");

        // Operand stability and start ignored during CALC
        a     = 4'd6;
        b     = 4'd7;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        a     = 4'd15;
        b     = 4'd15;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("stab_done_low", {7'd0, done}, 8'd0);
        @(negedge clock);
        check("stab_result", ab_result, 8'd42);
        check("stab_done", {7'd0, done}, 8'd1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            check("stab_single_done", {7'd0, done}, 8'd0);
            check("stab_keep", ab_result, 8'd42);
        end
        prev_result = 8'd42;

        // Abort on the second CALC cycle
        a     = 4'd9;
        b     = 4'd9;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("abort_result", ab_result, 8'd0);
        check("abort_done", {7'd0, done}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("abort_no_done", {7'd0, done}, 8'd0);
            check("abort_idle", ab_result, 8'd0);
        end
        prev_result = 8'd0;
        run_op(4'd9, 4'd9, 8'd81, "mul_9x9");

        // Back-to-back with start held high
        a     = 4'd4;
        b     = 4'd3;
        start = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clock);
            check("b2b_done", {7'd0, done}, (k % 6 == 5) ? 8'd1 : 8'd0);
            check("b2b_result", ab_result, (k < 5) ? 8'd81 : 8'd12);
        end
        start = 1'b0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
